lfsr_offset_finder: RTL and testbench
=====================================

# lfsr_offset_finder

Locates the position of a captured 17-bit LFSR word within the sequence generated from a known seed and polynomial. It does this by stepping an internal LFSR from the seed, one state per cycle, until the state equals the target word. The block sits downstream of the sensor bit-capture logic and converts a demodulated Lighthouse LFSR snapshot into an iteration offset for timing reconstruction. It uses the same step rule as the team's LFSR generator, so the reported offset equals that generator's iteration count for the same state.

## Interface
Parameters:
- MAX_ITER, 131071: number of states compared before giving up; legal range 1..131071.

Ports:
- clk_96MHz  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- polynomial  input  17  tap mask; sampled when start is accepted.
- start_data  input  17  seed, which is iteration 0; sampled when start is accepted.
- target  input  17  word to locate; sampled when start is accepted.
- start  input  1  request a search; honoured only in IDLE.
- abort  input  1  cancel the search in progress.
- busy  output  1  high in LOAD and SEARCH.
- done  output  1  one-cycle pulse when a search ends.
- found  output  1  result flag; held until the next accepted start.
- offset  output  17  iteration index of the match; held until the next accepted start.

## Operation
- Step rule: next = {v[15:0], ^(v & poly)}, a 17-bit shift left with the feedback bit entering at the LSB.
- Reset: state = IDLE. busy, done, found and offset are all 0. Internal value, count and captured inputs are 0.
- IDLE:
  - start=1 → capture polynomial, start_data and target.
  - Clear found and offset.
  - Go to LOAD.
- LOAD: value ← seed, count ← 0, go to SEARCH.
- SEARCH, each cycle, in priority order:
  1. abort=1 → go to IDLE. No done pulse; found stays 0.
  2. value == target → offset ← count, found ← 1, done ← 1, go to IDLE.
  3. count == MAX_ITER-1 → found ← 0, done ← 1, go to IDLE.
  4. Otherwise value ← next(value), count ← count+1.
- start while busy: ignored, with no effect on the search.
- abort outside SEARCH: ignored.
- Zero seed: the sequence stays at 0. target=0 gives offset 0; any other target times out.
- Matches are reported at the first occurrence only. A target that repeats within MAX_ITER reports its lowest index.
- Counter: 17 bits, never wraps because the search terminates at MAX_ITER-1.
- abort and start in the same IDLE cycle: start wins.

## Timing
- Counted from the clock edge that samples start=1:
  - busy goes high after edge 1.
  - A match at index k raises done after edge k+2.
  - busy drops in the same cycle that done goes high.
- Timeout: done after edge MAX_ITER+1, with found=0.
- done lasts exactly one cycle.
- found and offset are valid from the done cycle onward.
- A new start is accepted on the cycle in which done is high, because the state is already IDLE.
- Throughput: one state compared per cycle.
- Reset asserted mid-search forces all outputs to 0 immediately (asynchronous).

## Configuration
- LFSR_OFFSET_DUAL_STEP_EN defined: SEARCH compares value (index count) and next(value) (index count+1) in the same cycle.
  - A match on value takes priority.
  - Otherwise, advance by two states: value ← next(next(value)), count ← count+2.
  - A match at index k raises done after edge floor(k/2)+2.
  - Timeout occurs when count+1 ≥ MAX_ITER-1. Index MAX_ITER is never reported.
- Undefined: single-step behaviour exactly as described above.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_WIDTH = 17.
  - The state encodings IDLE, LOAD and SEARCH.
  - LFSR_PERIOD_MAX = 131071.
- Sub-module lfsr_step: purely combinational, (value, polynomial) → next value. It is instantiated once, or twice in dual-step mode. The generator uses the same module so both blocks share one step definition.

## Test plan
- Basic match: poly=17'h10000 (pure rotate), seed=17'h00001, target=17'h00008.
  - Expect done after edge 5, found=1, offset=3.
- Immediate match: seed=target=17'h1ACE5, any polynomial.
  - Expect done after edge 2, found=1, offset=0.
- Timeout: MAX_ITER=20, rotate polynomial, seed=17'h00001, target=17'h00003.
  - Expect done after edge 21, found=0, offset=0.
- Abort and ignored start: abort=1 at edge 6 of the basic-match setup with target=17'h10000.
  - Expect IDLE with no done pulse and found=0.
  - A start pulse at edge 3 has no effect.
- Reset mid-search: assert reset at cycle 4.
  - Expect busy, done, found and offset all 0 immediately.
  - A fresh start then completes normally.
- Dual-step (macro defined): basic-match setup with target=17'h00010 (k=4).
  - Expect done after edge 4, offset=4.
  - With target=17'h00008 (k=3), expect done after edge 3, offset=3.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR offset finder and its step function:
// word width, maximal-length period and the finder FSM state encodings.
package lfsr_pkg;

    localparam int LFSR_WIDTH      = 17;
    localparam int LFSR_PERIOD_MAX = 131071;

    typedef logic [LFSR_WIDTH-1:0] lfsr_word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SEARCH = 2'd2
    } finder_state_t;

endpackage

// File: rtl/lfsr_step.sv
// One LFSR step: shift left by one, feedback (parity of value & polynomial)
// enters at the LSB. Purely combinational; shared with the LFSR generator so
// both blocks agree on what "one iteration" means.
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0] value,
    input  logic [LFSR_WIDTH-1:0] polynomial,
    output logic [LFSR_WIDTH-1:0] next_value
);

    // Shift left, XOR-reduced tapped bits become the new LSB.
    always_comb begin
        next_value = {value[LFSR_WIDTH-2:0], ^(value & polynomial)};
    end

endmodule

// File: rtl/lfsr_offset_finder.sv
// Finds the iteration index of a target word in the LFSR sequence that starts
// at a given seed. One state compared per cycle; the seed (index 0) is
// compared in the LOAD cycle so that a match at index k ends after edge k+2.
//
// Optional feature: define LFSR_OFFSET_DUAL_STEP_EN to compare two
// consecutive states per cycle (index count and count+1) and advance by two.
//
// Handshake: start is a level sampled only in IDLE; busy is high in LOAD and
// SEARCH; done pulses for one cycle as the FSM returns to IDLE, and found and
// offset are valid from that cycle until the next accepted start. abort is
// only acted upon in SEARCH and ends the search without a done pulse.
module lfsr_offset_finder
    import lfsr_pkg::*;
#(
    parameter int MAX_ITER = LFSR_PERIOD_MAX
) (
    input  logic                  clk_96MHz,
    input  logic                  reset,
    input  logic [LFSR_WIDTH-1:0] polynomial,
    input  logic [LFSR_WIDTH-1:0] start_data,
    input  logic [LFSR_WIDTH-1:0] target,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [LFSR_WIDTH-1:0] offset
);

    // Highest index ever compared.
    localparam lfsr_word_t LAST_IDX  = lfsr_word_t'(MAX_ITER - 1);
    // With a single state to compare, the seed check in LOAD is the whole search.
    localparam logic       ONE_STATE = (MAX_ITER == 1);

    finder_state_t state, state_d;

    lfsr_word_t value_q,  value_d;
    lfsr_word_t count_q,  count_d;
    lfsr_word_t poly_q,   poly_d;
    lfsr_word_t seed_q,   seed_d;
    lfsr_word_t target_q, target_d;
    lfsr_word_t offset_q, offset_d;
    logic       found_q,  found_d;
    logic       done_q,   done_d;

    // In LOAD the step chain starts from the seed, in SEARCH from value.
    lfsr_word_t step_in;
    lfsr_word_t step1;

    assign step_in = (state == LOAD) ? seed_q : value_q;

    lfsr_step u_step1 (
        .value      (step_in),
        .polynomial (poly_q),
        .next_value (step1)
    );

`ifdef LFSR_OFFSET_DUAL_STEP_EN
    // Up to two states may be compared in the LOAD cycle, so the LOAD
    // timeout covers MAX_ITER of one or two.
    localparam logic TWO_OR_LESS = (MAX_ITER <= 2);

    lfsr_word_t             step2;
    logic [LFSR_WIDTH:0]    count_p1;

    assign count_p1 = {1'b0, count_q} + {{LFSR_WIDTH{1'b0}}, 1'b1};

    lfsr_step u_step2 (
        .value      (step1),
        .polynomial (poly_q),
        .next_value (step2)
    );
`endif

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            value_q  <= '0;
            count_q  <= '0;
            poly_q   <= '0;
            seed_q   <= '0;
            target_q <= '0;
            offset_q <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            value_q  <= value_d;
            count_q  <= count_d;
            poly_q   <= poly_d;
            seed_q   <= seed_d;
            target_q <= target_d;
            offset_q <= offset_d;
            found_q  <= found_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-datapath logic; done defaults low so it pulses once.
    always_comb begin
        state_d  = state;
        value_d  = value_q;
        count_d  = count_q;
        poly_d   = poly_q;
        seed_d   = seed_q;
        target_d = target_q;
        offset_d = offset_q;
        found_d  = found_q;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    poly_d   = polynomial;
                    seed_d   = start_data;
                    target_d = target;
                    found_d  = 1'b0;
                    offset_d = '0;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
`ifdef LFSR_OFFSET_DUAL_STEP_EN
                if (seed_q == target_q) begin
                    offset_d = '0;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (!ONE_STATE && (step1 == target_q)) begin
                    offset_d = lfsr_word_t'(1);
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (TWO_OR_LESS) begin
                    found_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    value_d  = step2;
                    count_d  = lfsr_word_t'(2);
                    state_d  = SEARCH;
                end
`else
                if (seed_q == target_q) begin
                    offset_d = '0;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (ONE_STATE) begin
                    found_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    value_d  = step1;
                    count_d  = lfsr_word_t'(1);
                    state_d  = SEARCH;
                end
`endif
            end

            SEARCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (value_q == target_q) begin
                    offset_d = count_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
`ifdef LFSR_OFFSET_DUAL_STEP_EN
                end else if ((count_p1 <= {1'b0, LAST_IDX}) && (step1 == target_q)) begin
                    offset_d = count_p1[LFSR_WIDTH-1:0];
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (count_p1 >= {1'b0, LAST_IDX}) begin
                    found_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    value_d  = step2;
                    count_d  = count_q + lfsr_word_t'(2);
                end
`else
                end else if (count_q == LAST_IDX) begin
                    found_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    value_d  = step1;
                    count_d  = count_q + lfsr_word_t'(1);
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = done_q;
    assign found  = found_q;
    assign offset = offset_q;

endmodule

// File: tb/tb_lfsr_offset_finder.sv
// Directed bench for lfsr_offset_finder (MAX_ITER = 20). Expected offsets and
// completion edges are hand-derived from the step rule; edge 1 is the edge
// that samples start. Outputs are sampled on the falling edge.
module tb_lfsr_offset_finder;

    localparam logic [16:0] ROT = 17'h10000;

`ifdef LFSR_OFFSET_DUAL_STEP_EN
    localparam int TO_EDGE = 11;
`else
    localparam int TO_EDGE = 21;
`endif

    logic        clk_96MHz = 1'b0;
    logic        reset;
    logic [16:0] polynomial;
    logic [16:0] start_data;
    logic [16:0] target;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        found;
    logic [16:0] offset;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_offset_finder #(.MAX_ITER(20)) dut (
        .clk_96MHz  (clk_96MHz),
        .reset      (reset),
        .polynomial (polynomial),
        .start_data (start_data),
        .target     (target),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .offset     (offset)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_edge(input int k);
`ifdef LFSR_OFFSET_DUAL_STEP_EN
        return k / 2 + 2;
`else
        return k + 2;
`endif
    endfunction

    // Caller is at a falling edge. Returns at the falling edge of the done cycle.
    task automatic run_search(input string tag, input logic [16:0] p, input logic [16:0] s,
                              input logic [16:0] t, input logic exp_found,
                              input logic [16:0] exp_off, input int exp_e);
        int e;
        polynomial = p;
        start_data = s;
        target     = t;
        start      = 1'b1;
        @(posedge clk_96MHz);
        e = 1;
        @(negedge clk_96MHz);
        start = 1'b0;
        check_eq({tag, "_busy_e1"}, busy, 1);
        check_eq({tag, "_found_clr"}, found, 0);
        while (!done && e < 200) begin
            @(posedge clk_96MHz);
            e++;
            @(negedge clk_96MHz);
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_edge"}, e, exp_e);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_found"}, found, exp_found);
        check_eq({tag, "_offset"}, offset, exp_off);
    endtask

    // One cycle after done: pulse over, results held.
    task automatic done_drop(input string tag, input logic exp_found, input logic [16:0] exp_off);
        @(negedge clk_96MHz);
        check_eq({tag, "_done_drop"}, done, 0);
        check_eq({tag, "_found_hold"}, found, exp_found);
        check_eq({tag, "_offset_hold"}, offset, exp_off);
    endtask

    initial begin
        int e;
        logic saw_done;

        reset      = 1'b0;
        polynomial = '0;
        start_data = '0;
        target     = '0;
        start      = 1'b0;
        abort      = 1'b0;
        #1 reset   = 1'b1;
        repeat (2) @(negedge clk_96MHz);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_found", found, 0);
        check_eq("rst_offset", offset, 0);
        reset = 1'b0;
        @(negedge clk_96MHz);

        // Seed equals target: index 0.
        run_search("imm", 17'h12345, 17'h1ACE5, 17'h1ACE5, 1'b1, 17'd0, exp_edge(0));
        done_drop("imm", 1'b1, 17'd0);

        // Rotate: 1,2,4,8 -> index 3; then a start accepted in the done cycle.
        run_search("basic", ROT, 17'h00001, 17'h00008, 1'b1, 17'd3, exp_edge(3));
        run_search("chain", ROT, 17'h10000, 17'h00001, 1'b1, 17'd1, exp_edge(1));
        done_drop("chain", 1'b1, 17'd1);

        run_search("k4", ROT, 17'h00001, 17'h00010, 1'b1, 17'd4, exp_edge(4));
        done_drop("k4", 1'b1, 17'd4);

        // Taps on bits 0,1: 1 -> 3 -> 6 -> D -> 1B, index 4.
        run_search("poly3", 17'h00003, 17'h00001, 17'h0001B, 1'b1, 17'd4, exp_edge(4));
        done_drop("poly3", 1'b1, 17'd4);

        // 2 occurs at index 1 and again at 18; the first wins.
        run_search("repeat", ROT, 17'h00001, 17'h00002, 1'b1, 17'd1, exp_edge(1));
        done_drop("repeat", 1'b1, 17'd1);

        run_search("timeout", ROT, 17'h00001, 17'h00003, 1'b0, 17'd0, TO_EDGE);
        done_drop("timeout", 1'b0, 17'd0);

        run_search("zero_hit", 17'h1FFFF, 17'h00000, 17'h00000, 1'b1, 17'd0, exp_edge(0));
        done_drop("zero_hit", 1'b1, 17'd0);
        run_search("zero_miss", 17'h1FFFF, 17'h00000, 17'h00005, 1'b0, 17'd0, TO_EDGE);
        done_drop("zero_miss", 1'b0, 17'd0);

        // Start while busy (edge 3) must not disturb the running search.
        polynomial = ROT; start_data = 17'h00001; target = 17'h00010; start = 1'b1;
        @(posedge clk_96MHz); e = 1;
        @(negedge clk_96MHz); start = 1'b0;
        @(posedge clk_96MHz); e = 2;
        @(negedge clk_96MHz);
        polynomial = 17'h00003; start_data = 17'h00005; target = 17'h00002; start = 1'b1;
        @(posedge clk_96MHz); e = 3;
        @(negedge clk_96MHz); start = 1'b0;
        while (!done && e < 200) begin
            @(posedge clk_96MHz); e++;
            @(negedge clk_96MHz);
        end
        check_eq("busy_start_edge", e, exp_edge(4));
        check_eq("busy_start_found", found, 1);
        check_eq("busy_start_offset", offset, 4);
        done_drop("busy_start", 1'b1, 17'd4);

        // start and abort together in IDLE: start wins; abort in LOAD ignored.
        polynomial = ROT; start_data = 17'h00001; target = 17'h00008;
        start = 1'b1; abort = 1'b1;
        @(posedge clk_96MHz); e = 1;
        @(negedge clk_96MHz); start = 1'b0;
        check_eq("start_wins_busy", busy, 1);
        @(posedge clk_96MHz); e = 2;
        @(negedge clk_96MHz); abort = 1'b0;
        check_eq("abort_load_busy", busy | done, 1);
        while (!done && e < 200) begin
            @(posedge clk_96MHz); e++;
            @(negedge clk_96MHz);
        end
        check_eq("abort_load_edge", e, exp_edge(3));
        check_eq("abort_load_offset", offset, 3);
        done_drop("abort_load", 1'b1, 17'd3);

        // Abort at edge 6 while searching for index 16.
        saw_done = 1'b0;
        polynomial = ROT; start_data = 17'h00001; target = 17'h10000; start = 1'b1;
        @(posedge clk_96MHz); e = 1;
        @(negedge clk_96MHz); start = 1'b0;
        while (e < 5) begin
            @(posedge clk_96MHz); e++;
            @(negedge clk_96MHz);
            saw_done = saw_done | done;
        end
        abort = 1'b1;
        @(posedge clk_96MHz); e = 6;
        @(negedge clk_96MHz); abort = 1'b0;
        saw_done = saw_done | done;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_found", found, 0);
        check_eq("abort_offset", offset, 0);
        repeat (15) begin
            @(negedge clk_96MHz);
            saw_done = saw_done | done;
        end
        check_eq("abort_no_done", saw_done, 0);

        // Reset mid-search (after edge 4) clears outputs without a clock edge.
        polynomial = ROT; start_data = 17'h00001; target = 17'h10000; start = 1'b1;
        @(posedge clk_96MHz);
        @(negedge clk_96MHz); start = 1'b0;
        repeat (3) @(negedge clk_96MHz);
        check_eq("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        @(negedge clk_96MHz); reset = 1'b0;
        @(negedge clk_96MHz);

        // Reset while a result is held clears found and offset immediately.
        run_search("pre_rst", ROT, 17'h00001, 17'h00010, 1'b1, 17'd4, exp_edge(4));
        @(negedge clk_96MHz);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_held_found", found, 0);
        check_eq("rst_held_offset", offset, 0);
        check_eq("rst_held_busy", busy, 0);
        @(negedge clk_96MHz); reset = 1'b0;
        @(negedge clk_96MHz);

        run_search("post_rst", ROT, 17'h00001, 17'h00008, 1'b1, 17'd3, exp_edge(3));
        done_drop("post_rst", 1'b1, 17'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
